// File: rtl/gate_exerciser_3_inputs.sv
// Sweeps all eight input vectors into a 3-input gate, samples its Result after a
// settle delay and records per-vector mismatches against a built-in gate model.
module gate_exerciser_3_inputs #(
  parameter logic [2:0]  BubblesMask  = 3'd1,
  parameter int unsigned GateType     = 1,
  parameter int unsigned SettleCycles = 2
) (
  input  logic       GlobalClock,
  input  logic       nReset,
  input  logic       Start,
  input  logic       DUT_Result,
  output logic       Input_1,
  output logic       Input_2,
  output logic       Input_3,
  output logic [2:0] VectorIndex,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [7:0] MismatchMap
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [3:0] SETTLE = 4'(SettleCycles);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] map_q, map_d;
  logic       pass_q, pass_d;
  logic       miss;
  logic [7:0] map_upd;

  function automatic logic model(input logic [2:0] idx);
    logic [2:0] r;
    r = idx ^ BubblesMask;
    case (GateType)
      0:       model = &r;
      1:       model = ~&r;
      2:       model = |r;
      3:       model = ~|r;
      4:       model = ^r;
      5:       model = ~^r;
      default: model = ~&r;
    endcase
  endfunction

  always_comb begin
    miss    = (DUT_Result != model(idx_q));
    map_upd = map_q | (8'(miss) << idx_q);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    map_d   = map_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d = ST_RUN;
          idx_d   = 3'd0;
          cnt_d   = SETTLE;
          map_d   = 8'h00;
          pass_d  = 1'b0;
        end
      end
      ST_RUN: begin
        // The sample edge is the one that would bring the counter to zero.
        if (cnt_q <= 4'd1) begin
          map_d = map_upd;
          if (idx_q == 3'd7) begin
            state_d = ST_DONE;
            cnt_d   = 4'd0;
            pass_d  = (map_upd == 8'h00);
          end else begin
            idx_d = idx_q + 3'd1;
            cnt_d = SETTLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge GlobalClock or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      map_q   <= 8'h00;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      map_q   <= map_d;
      pass_q  <= pass_d;
    end
  end

  // Stimulus comes straight from the index register; it is 0 in IDLE.
  assign Input_1     = idx_q[0];
  assign Input_2     = idx_q[1];
  assign Input_3     = idx_q[2];
  assign VectorIndex = idx_q;
  assign Busy        = (state_q == ST_RUN);
  assign Done        = (state_q == ST_DONE);
  assign Pass        = pass_q;
  assign MismatchMap = map_q;

endmodule

// File: tb/tb_gate_exerciser_3_inputs.sv
// Bench for gate_exerciser_3_inputs: three instances (NAND w/ bubble, AND, XOR)
// each driven by a behavioural gate or a stuck result.
module tb_gate_exerciser_3_inputs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start, res, in1, in2, in3, busy, done, pass;
  logic [2:0] vidx [3];
  logic [7:0] mmap [3];
  int         mode [3];          // 0 real gate, 1 stuck-0, 2 stuck-1
  int         settle [3] = '{2, 1, 3};
  int         checks   = 0;
  int         failures = 0;

  typedef struct {
    int         inst;
    int         mode;
    logic [7:0] map;
    logic       pass;
    bit         toggle;
  } vec_t;

  typedef struct {
    int         inst;
    logic [7:0] map;
    logic       pass;
  } exp_t;

  vec_t vecs [10];
  exp_t sb_q [$];

  gate_exerciser_3_inputs #(.BubblesMask(3'd1), .GateType(1), .SettleCycles(2)) u_nand (
    .GlobalClock(clk), .nReset(rst_n), .Start(start[0]), .DUT_Result(res[0]),
    .Input_1(in1[0]), .Input_2(in2[0]), .Input_3(in3[0]), .VectorIndex(vidx[0]),
    .Busy(busy[0]), .Done(done[0]), .Pass(pass[0]), .MismatchMap(mmap[0]));

  gate_exerciser_3_inputs #(.BubblesMask(3'd0), .GateType(0), .SettleCycles(1)) u_and (
    .GlobalClock(clk), .nReset(rst_n), .Start(start[1]), .DUT_Result(res[1]),
    .Input_1(in1[1]), .Input_2(in2[1]), .Input_3(in3[1]), .VectorIndex(vidx[1]),
    .Busy(busy[1]), .Done(done[1]), .Pass(pass[1]), .MismatchMap(mmap[1]));

  gate_exerciser_3_inputs #(.BubblesMask(3'd0), .GateType(4), .SettleCycles(3)) u_xor (
    .GlobalClock(clk), .nReset(rst_n), .Start(start[2]), .DUT_Result(res[2]),
    .Input_1(in1[2]), .Input_2(in2[2]), .Input_3(in3[2]), .VectorIndex(vidx[2]),
    .Busy(busy[2]), .Done(done[2]), .Pass(pass[2]), .MismatchMap(mmap[2]));

  // Gates under exercise: NAND3 with input 1 inverted, AND3, XOR3.
  function automatic logic gate_out(input int i, input logic a, input logic b, input logic c);
    case (i)
      0:       gate_out = ~((~a) & b & c);
      1:       gate_out = a & b & c;
      default: gate_out = a ^ b ^ c;
    endcase
  endfunction

  always_comb begin
    res = '0;
    for (int i = 0; i < 3; i++) begin
      if (mode[i] == 1)      res[i] = 1'b0;
      else if (mode[i] == 2) res[i] = 1'b1;
      else                   res[i] = gate_out(i, in1[i], in2[i], in3[i]);
    end
  end

  function automatic logic [16:0] all_outs(input int i);
    all_outs = {in1[i], in2[i], in3[i], busy[i], done[i], pass[i], vidx[i], mmap[i]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One full sweep: expectation pushed when Start is driven, popped when Done shows.
  task automatic run_sweep(input int inst, input bit toggle, input logic [7:0] emap, input logic epass);
    int   n;
    int   bad;
    exp_t e;
    @(negedge clk);
    start[inst] = 1'b1;
    sb_q.push_back('{inst, emap, epass});
    @(negedge clk);
    start[inst] = 1'b0;
    n   = 0;
    bad = 0;
    while (busy[inst] && n < 300) begin
      if (vidx[inst] !== 3'(n / settle[inst])) bad++;
      if ({in3[inst], in2[inst], in1[inst]} !== vidx[inst]) bad++;
      if (toggle) start[inst] = n[0];
      n++;
      @(negedge clk);
    end
    start[inst] = 1'b0;
    e = sb_q.pop_front();
    check($sformatf("busy_cycles[%0d]", e.inst), 32'(n), 32'(8 * settle[e.inst]));
    check($sformatf("done[%0d]", e.inst), 32'(done[e.inst]), 32'd1);
    check($sformatf("map[%0d]", e.inst), 32'(mmap[e.inst]), 32'(e.map));
    check($sformatf("pass[%0d]", e.inst), 32'(pass[e.inst]), 32'(e.pass));
    check($sformatf("index_seq[%0d]", e.inst), 32'(bad), 32'd0);
    check($sformatf("final_idx[%0d]", e.inst), 32'(vidx[e.inst]), 32'd7);
    @(negedge clk);
    check($sformatf("done_hold[%0d]", e.inst),
          32'({done[e.inst], busy[e.inst], mmap[e.inst], in3[e.inst], in2[e.inst], in1[e.inst]}),
          32'({1'b1, 1'b0, e.map, 3'b111}));
    $display("sweep inst=%0d map=0x%02h pass=%0d busy_cycles=%0d", e.inst, mmap[e.inst], pass[e.inst], n);
  endtask

  initial begin
    int   n;
    int   dcount;
    exp_t e;

    vecs[0] = '{0, 0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{0, 2, 8'h40, 1'b0, 1'b0};
    vecs[2] = '{0, 1, 8'hBF, 1'b0, 1'b0};
    vecs[3] = '{1, 0, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{1, 1, 8'h80, 1'b0, 1'b0};
    vecs[5] = '{1, 2, 8'h7F, 1'b0, 1'b0};
    vecs[6] = '{2, 0, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{2, 1, 8'h96, 1'b0, 1'b0};
    vecs[8] = '{0, 0, 8'h00, 1'b1, 1'b1};
    vecs[9] = '{2, 2, 8'h69, 1'b0, 1'b0};

    rst_n = 1'b1;
    start = '0;
    mode  = '{0, 0, 0};
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("reset_outs[%0d]", i), 32'(all_outs(i)), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("idle_outs[%0d]", i), 32'(all_outs(i)), 32'd0);

    for (int v = 0; v < 10; v++) begin
      mode[vecs[v].inst] = vecs[v].mode;
      run_sweep(vecs[v].inst, vecs[v].toggle, vecs[v].map, vecs[v].pass);
    end

    // Asynchronous reset while vector 4 is driven.
    mode[0] = 0;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (vidx[0] !== 3'd4 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("reach_vec4", 32'(vidx[0]), 32'd4);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outs", 32'(all_outs(0)), 32'd0);
    $display("async reset mid-sweep outs=0x%05h", all_outs(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", 32'(all_outs(0)), 32'd0);
    run_sweep(0, 1'b0, 8'h00, 1'b1);

    // Start held high through DONE: restart after exactly one DONE cycle.
    mode[2] = 1;
    @(negedge clk);
    start[2] = 1'b1;
    sb_q.push_back('{2, 8'h96, 1'b0});
    n = 0;
    while (!done[2] && n < 300) begin
      n++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    check("hold_first_done", 32'(done[2]), 32'd1);
    check("hold_first_map", 32'(mmap[e.inst]), 32'(e.map));
    @(negedge clk);
    check("hold_restart", 32'({done[2], busy[2], mmap[2], vidx[2]}), 32'({1'b0, 1'b1, 8'h00, 3'd0}));
    start[2] = 1'b0;
    sb_q.push_back('{2, 8'h96, 1'b0});
    dcount = 0;
    n = 0;
    while (!done[2] && n < 300) begin
      n++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    repeat (3) begin
      if (done[2]) dcount++;
      @(negedge clk);
    end
    check("second_done_hold", 32'(dcount), 32'd3);
    check("second_map", 32'(mmap[e.inst]), 32'(e.map));
    check("second_pass", 32'(pass[e.inst]), 32'(e.pass));
    $display("hold-start restart map=0x%02h pass=%0d", mmap[2], pass[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_exerciser_3_inputs.md
# gate_exerciser_3_inputs

Self-checking stimulus/response block for the 3-input gate library. It drives all eight input combinations into a gate instance and samples that gate's `Result`. Each sample is compared against a built-in model of the same gate type and bubble mask, and mismatches are recorded per vector. It sits on the FPGA prototype beside the gate under exercise and is the consumer end of the gate's `Input_1..3`/`Result` interface. Students use it for board-level checks of generated gates.

## Interface
Parameters:
- `BubblesMask`, 1: 3-bit input inversion mask applied by the model; bit i inverts input i+1.
- `GateType`, 1: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR (odd parity), 5 XNOR; 6 and 7 behave as NAND.
- `SettleCycles`, 2: cycles from driving a vector to sampling it; legal range 1..15.

Ports:
- `GlobalClock`  in  1  single clock; all state is updated on the rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  level, sampled each edge; begins a sweep from IDLE or DONE.
- `DUT_Result`  in  1  `Result` of the gate under exercise.
- `Input_1`, `Input_2`, `Input_3`  out  1 each  registered stimulus to the gate.
- `VectorIndex`  out  3  index of the vector currently driven.
- `Busy`  out  1  high while in RUN.
- `Done`  out  1  high while in DONE.
- `Pass`  out  1  high in DONE when `MismatchMap` is 0.
- `MismatchMap`  out  8  bit k set when vector k mismatched.

## Operation
- States are IDLE, RUN and DONE.
- Vector mapping: `Input_1`=idx[0], `Input_2`=idx[1], `Input_3`=idx[2]. `VectorIndex`=idx.
- Model: real_i = idx[i] XOR `BubblesMask`[i]. The expected value is `GateType` applied to real_0..2.
- IDLE or DONE, with `Start`=1 at an edge, transitions to RUN. On that edge:
  - idx←0 and inputs←000;
  - the settle counter loads `SettleCycles`;
  - `MismatchMap`←0, `Pass`←0, `Done`←0.
- RUN: the settle counter decrements every edge. On the edge where it would reach 0:
  - sample `DUT_Result`;
  - set `MismatchMap`[idx] if the sample ≠ the expected value;
  - if idx<7: idx←idx+1, drive the new vector, reload the counter with `SettleCycles`;
  - if idx=7: enter DONE, keep driving vector 7, set `Done`=1, set `Pass`=(final map==0).
- RUN ignores `Start`. A sweep always runs to completion.
- DONE holds `MismatchMap`, `Pass` and the inputs until the next `Start`.
- IDLE with `Start`=0 stays IDLE and drives inputs 000.
- `nReset`=0 at any time, including mid-RUN, immediately forces:
  - IDLE, idx=0, counter=0;
  - all outputs to 0.
- After reset deasserts, the block waits for a fresh `Start`. No partial-sweep state survives.

## Timing
- Reset values: `Input_1..3`=0, `VectorIndex`=0, `Busy`=0, `Done`=0, `Pass`=0, `MismatchMap`=0x00.
- Let E0 be the `Start` edge. Vector k is driven from edge E0+k·`SettleCycles`. It is sampled on edge E0+(k+1)·`SettleCycles`, the same edge that drives vector k+1.
- `Busy` rises at E0 and falls at E0+8·`SettleCycles`, where `Done` rises. There is no gap cycle.
- All outputs are registered. The block has no combinational path from `DUT_Result` to any output.
- `Start` held high in DONE restarts on the next edge. The DONE state is then visible for exactly 1 cycle.

## Test plan
- **NAND_GATE_3_INPUTS with `BubblesMask`=1, model `GateType`=1, `SettleCycles`=2; pulse `Start`.**
  - `Busy` is high for 16 cycles, then `Done`=1, `Pass`=1, `MismatchMap`=0x00.
  - Expected `Result` is 0 only at idx 6.
- **Same setup, but `DUT_Result` is forced to 1.**
  - `Done` arrives after 16 cycles with `MismatchMap`=0x40, `Pass`=0.
- **Model `GateType`=0 (AND) with an AND gate, `BubblesMask`=0, `SettleCycles`=1.**
  - `Done` after 8 cycles, `Pass`=1.
  - Then tie `DUT_Result`=0: `MismatchMap`=0x80.
- **Assert `nReset`=0 during vector 4 of a sweep.**
  - All outputs are 0 asynchronously, before the next edge.
  - After release, state stays IDLE until `Start`. A new sweep starts cleanly.
- **Toggle `Start` mid-RUN.**
  - No effect: `VectorIndex` continues monotonically 0..7.
- **Hold `Start` high in DONE.**
  - Restart on the next edge, `MismatchMap` cleared, `Done` high for exactly 1 cycle.
  - XOR model (`GateType`=4) with a stuck-0 result gives `MismatchMap`=0x96.
